// File: rtl/q_max_select_if.sv
// Bus between the maze controller / Q-table and the q_max_select row scanner.
interface q_max_select_if #(
  parameter int NUM_STATES  = 37,
  parameter int NUM_ACTIONS = 4
) ();
  logic                                         start;
  logic [5:0]                                   state_i;
  logic [NUM_STATES-1:0][NUM_ACTIONS-1:0][31:0] q_table;
  logic [31:0]                                  max_q;
  logic [3:0]                                   greedy_action;
  logic [3:0]                                   action;
  logic                                         busy;
  logic                                         done_o;
  logic                                         err;

  modport master (
    output start, state_i, q_table,
    input  max_q, greedy_action, action, busy, done_o, err
  );

  modport slave (
    input  start, state_i, q_table,
    output max_q, greedy_action, action, busy, done_o, err
  );
endinterface

// File: rtl/q_max_select.sv
// Sequential row scanner returning max Q, its action index and the next action.
// Optional epsilon-greedy exploration enabled by defining EPSILON_GREEDY_EN.
module q_max_select #(
  parameter int NUM_STATES  = 37,
  parameter int NUM_ACTIONS = 4
`ifdef EPSILON_GREEDY_EN
  ,
  parameter logic [7:0]  EPSILON   = 8'd26,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
  input logic           clk,
  input logic           rst,
  q_max_select_if.slave bus
);
  localparam int IDX_W = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [5:0]         row_r, row_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic signed [31:0] run_max_r, run_max_s;
  logic [3:0]         run_idx_r, run_idx_s;
  logic [31:0]        max_q_r, max_q_s;
  logic [3:0]         greedy_r, greedy_s;
  logic [3:0]         action_r, action_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               err_r, err_s;
  logic signed [31:0] cur_q_s;
  logic [3:0]         pick_s;

  assign cur_q_s = $signed(bus.q_table[row_r][idx_r]);

`ifdef EPSILON_GREEDY_EN
  logic [15:0] lfsr_r;

  // Free-running Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end
  end

  // Explore on a low draw; an errored scan always reports action 0.
  always_comb begin
    pick_s = run_idx_r;
    if (!err_r && (lfsr_r[15:8] < EPSILON)) begin
      pick_s = 4'(32'(lfsr_r[1:0]) % NUM_ACTIONS);
    end else begin
      pick_s = run_idx_r;
    end
  end
`else
  assign pick_s = run_idx_r;
`endif

  // Next-state and next-value logic for the scan FSM.
  always_comb begin
    state_s   = state_r;
    row_s     = row_r;
    idx_s     = idx_r;
    run_max_s = run_max_r;
    run_idx_s = run_idx_r;
    max_q_s   = max_q_r;
    greedy_s  = greedy_r;
    action_s  = action_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    err_s     = err_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          row_s     = bus.state_i;
          busy_s    = 1'b1;
          idx_s     = '0;
          run_max_s = 32'sd0;
          run_idx_s = 4'd0;
          if (32'(bus.state_i) < NUM_STATES) begin
            err_s   = 1'b0;
            state_s = ST_SCAN;
          end else begin
            err_s   = 1'b1;
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        // Strict greater-than keeps the lowest index on ties.
        if (idx_r == '0) begin
          run_max_s = cur_q_s;
          run_idx_s = 4'd0;
        end else if (cur_q_s > run_max_r) begin
          run_max_s = cur_q_s;
          run_idx_s = 4'(idx_r);
        end else begin
          run_max_s = run_max_r;
        end
        if (idx_r == IDX_W'(NUM_ACTIONS - 1)) begin
          state_s = ST_DONE;
        end else begin
          idx_s = idx_r + IDX_W'(1);
        end
      end
      ST_DONE: begin
        max_q_s  = run_max_r;
        greedy_s = run_idx_r;
        action_s = pick_s;
        busy_s   = 1'b0;
        done_s   = 1'b1;
        state_s  = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_r     <= 6'd0;
      idx_r     <= '0;
      run_max_r <= 32'sd0;
      run_idx_r <= 4'd0;
      max_q_r   <= 32'd0;
      greedy_r  <= 4'd0;
      action_r  <= 4'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      row_r     <= row_s;
      idx_r     <= idx_s;
      run_max_r <= run_max_s;
      run_idx_r <= run_idx_s;
      max_q_r   <= max_q_s;
      greedy_r  <= greedy_s;
      action_r  <= action_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      err_r     <= err_s;
    end
  end

  assign bus.max_q         = max_q_r;
  assign bus.greedy_action = greedy_r;
  assign bus.action        = action_r;
  assign bus.busy          = busy_r;
  assign bus.done_o        = done_r;
  assign bus.err           = err_r;
endmodule

// File: tb/tb_q_max_select.sv
// Directed bench for q_max_select with hand-computed expected values.
module tb_q_max_select;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   lat;
  int   bcnt;
  int   first_done;
  int   second_done;
  int   explore_cnt;
  int   bad_action;

  q_max_select_if #(.NUM_STATES(37), .NUM_ACTIONS(4)) bus ();

`ifdef EPSILON_GREEDY_EN
  q_max_select #(.NUM_STATES(37), .NUM_ACTIONS(4), .EPSILON(8'd255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`else
  q_max_select #(.NUM_STATES(37), .NUM_ACTIONS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one start; returns periods from acceptance to done_o and busy-high periods.
  task automatic run_scan(input logic [5:0] st, input int pulse_at, output int l, output int b);
    l = -1;
    b = 0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.state_i = st;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (k == pulse_at) begin
        bus.start   = 1'b1;
        bus.state_i = 6'd3;
      end else if (k == pulse_at + 1) begin
        bus.start = 1'b0;
      end
      if (bus.busy) b++;
      if (bus.done_o) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input int exp_lat, input logic [31:0] exp_max,
                              input logic [3:0] exp_idx, input logic exp_err);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat));
    check({tag, "_max_q"}, bus.max_q, exp_max);
    check({tag, "_greedy"}, 32'(bus.greedy_action), 32'(exp_idx));
`ifndef EPSILON_GREEDY_EN
    check({tag, "_action"}, 32'(bus.action), 32'(exp_idx));
`endif
    check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b0;
    bus.start   = 1'b0;
    bus.state_i = 6'd0;
    bus.q_table = '0;
    bus.q_table[5][0] = 32'h00010000;
    bus.q_table[5][1] = 32'h0006E600;
    bus.q_table[5][2] = 32'hFFFF8000;
    bus.q_table[5][3] = 32'h00050000;
    bus.q_table[0][0] = 32'hFFFF0000;
    bus.q_table[0][1] = 32'hFFFE0000;
    bus.q_table[0][2] = 32'hFFFF8000;
    bus.q_table[0][3] = 32'hFFFC0000;
    bus.q_table[3][0] = 32'h00020000;
    bus.q_table[3][1] = 32'h00020000;
    bus.q_table[3][2] = 32'h00010000;
    bus.q_table[3][3] = 32'h00020000;

    repeat (3) @(negedge clk);
    check("rst_max_q", bus.max_q, 32'h0);
    check("rst_greedy", 32'(bus.greedy_action), 32'h0);
    check("rst_action", 32'(bus.action), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done_o), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    rst = 1'b1;

    run_scan(6'd5, -1, lat, bcnt);
    check_result("row5", 5, 32'h0006E600, 4'd1, 1'b0);
    @(negedge clk);
    check("row5_done_pulse", 32'(bus.done_o), 32'h0);
    check("row5_hold", bus.max_q, 32'h0006E600);

    run_scan(6'd0, -1, lat, bcnt);
    check_result("row0_neg", 5, 32'hFFFF8000, 4'd2, 1'b0);

    run_scan(6'd3, -1, lat, bcnt);
    check_result("row3_tie", 5, 32'h00020000, 4'd0, 1'b0);

    run_scan(6'd37, -1, lat, bcnt);
    check_result("oob", 1, 32'h0, 4'd0, 1'b0 | 1'b1);
    check("oob_action", 32'(bus.action), 32'h0);

    run_scan(6'd5, -1, lat, bcnt);
    check_result("after_oob", 5, 32'h0006E600, 4'd1, 1'b0);

    // Extra start during SCAN must be dropped.
    run_scan(6'd0, 2, lat, bcnt);
    check_result("busy_start", 5, 32'hFFFF8000, 4'd2, 1'b0);
    repeat (3) @(negedge clk);
    check("busy_start_no_requeue", 32'(bus.busy), 32'h0);

    // Reset in the middle of a scan.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.state_i = 6'd5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_max_q", bus.max_q, 32'h0);
    check("midrst_greedy", 32'(bus.greedy_action), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_err", 32'(bus.err), 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) rst = 1'b1;
      check("midrst_no_done", 32'(bus.done_o), 32'h0);
    end
    run_scan(6'd3, -1, lat, bcnt);
    check_result("post_rst", 5, 32'h00020000, 4'd0, 1'b0);

    // start held high: back-to-back scans six periods apart.
    first_done  = -1;
    second_done = -1;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.state_i = 6'd5;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.done_o) begin
        if (first_done < 0) begin
          first_done = k;
        end else begin
          second_done = k;
          bus.start   = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    check("held_first", 32'(first_done), 32'd5);
    check("held_spacing", 32'(second_done - first_done), 32'd6);
    repeat (3) @(negedge clk);

`ifdef EPSILON_GREEDY_EN
    explore_cnt = 0;
    bad_action  = 0;
    for (int s = 0; s < 256; s++) begin
      run_scan(6'd5, -1, lat, bcnt);
      if (bus.action != bus.greedy_action) explore_cnt++;
      if (bus.action > 4'd3) bad_action++;
      if (s == 0) check("eps_greedy", 32'(bus.greedy_action), 32'd1);
    end
    check("eps_explored", 32'(explore_cnt > 0), 32'd1);
    check("eps_range", 32'(bad_action), 32'd0);
`else
    explore_cnt = 0;
    bad_action  = 0;
    for (int s = 0; s < 8; s++) begin
      run_scan((s % 2 == 0) ? 6'd5 : 6'd0, -1, lat, bcnt);
      if (bus.action != bus.greedy_action) explore_cnt++;
    end
    check("greedy_only", 32'(explore_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/q_max_select.md
Name: q_max_select

Overview:
- Reader side of the Q-table update path: scans one state's row of the Q table and returns the largest Q value, its action index, and the action to take next.
- Produces the max_Q and action operands consumed by the Q-update block.
- Sits between the Q-table register array and the Q-update block, under control of the maze controller.
- Sequential scan, one action per clock, with a start/done handshake.

Parameters:
- NUM_STATES, 37, number of rows in the Q table.
- NUM_ACTIONS, 4, number of actions per state (columns scanned).
- EPSILON, 8'd26, exploration threshold out of 256 (about 10%); used only with the optional feature.
- LFSR_SEED, 16'hACE1, non-zero reset seed of the exploration LFSR.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a scan; sampled only in IDLE.
- state_i  input  6  row index to scan.
- q_table  input  32 x [37][4]  Q table in signed Q15.16; caller holds it stable from start until done_o.
- max_q  output  32  largest Q value of the row, signed Q15.16.
- greedy_action  output  4  index of max_q (0..NUM_ACTIONS-1).
- action  output  4  action to take next: greedy_action, or a random action (optional feature).
- busy  output  1  high from start acceptance until done_o.
- done_o  output  1  one-cycle pulse; outputs valid from this cycle.
- err  output  1  state_i was out of range on the last accepted start.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE.
  - max_q=0, greedy_action=0, action=0, busy=0, done_o=0, err=0.
  - Internal index and running max cleared; LFSR loaded with LFSR_SEED.
  - Reset mid-scan aborts the scan; no done_o is produced.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start=1 latches state_i into row_r and sets busy=1.
  - If state_i < NUM_STATES: idx=0, go to SCAN, err=0.
  - Otherwise: err=1, max_q=0, greedy_action=0, action=0, go to DONE with no table access.
- SCAN:
  - One column per cycle.
  - At idx=0, load run_max=q_table[row_r][0] and run_idx=0.
  - At idx>0, replace only if q_table[row_r][idx] is strictly greater, compared as signed 32-bit. Ties keep the lowest index.
  - idx increments each cycle. After idx=NUM_ACTIONS-1, go to DONE.
- DONE:
  - Register max_q=run_max and greedy_action=run_idx; resolve action.
  - done_o=1 and busy=0 in this cycle; next state is IDLE.
- Latency: start accepted at edge N → done_o high in cycle N+NUM_ACTIONS+1 (N+5 by default); out-of-range case → N+1.
- Outputs hold their values until the next DONE or reset.
- start while busy is ignored (not queued).
- start held high continuously: a new scan begins in the IDLE cycle after each DONE.
- Arithmetic: signed compare only; no saturation or truncation. Values pass through bit-exact.

Optional Feature:
- Macro: EPSILON_GREEDY_EN
- Defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11), advanced every clock while out of reset.
  - In DONE, if lfsr[15:8] < EPSILON, then action = lfsr[1:0] mod NUM_ACTIONS; otherwise action = greedy_action.
  - max_q and greedy_action are unaffected.
- Undefined:
  - No LFSR is instantiated; action always equals greedy_action.
  - EPSILON and LFSR_SEED are unused.

Test Plan:
- Row 5 = {0x00010000, 0x0006E600, 0xFFFF8000, 0x00050000}, start with state_i=5 → done_o 5 cycles later, max_q=0x0006E600, greedy_action=1, busy high for exactly 5 cycles.
- Row 0 all negative {0xFFFF0000, 0xFFFE0000, 0xFFFF8000, 0xFFFC0000} → max_q=0xFFFF8000, greedy_action=2 (signed compare, not unsigned).
- Ties, row 3 = {0x00020000, 0x00020000, 0x00010000, 0x00020000} → greedy_action=0, max_q=0x00020000.
- state_i=37 → done_o next cycle, err=1, max_q=0, action=0; then a valid start clears err.
- start pulsed during SCAN, and rst asserted mid-scan → extra start ignored; reset returns all outputs to 0 with no done_o; the next start runs normally.
- With EPSILON_GREEDY_EN, EPSILON=255, 256 scans of row 5 → action≠greedy_action at least once and always <4. With EPSILON=0, or macro undefined → action=greedy_action every scan.
